// File: rtl/cache_pkg.sv
// Shared types for the cache replacement controller: way count, way index
// type, controller state encoding and a lowest-set-bit helper.
package cache_pkg;

    localparam int unsigned NWAYS = 4;

    typedef logic [1:0] way_t;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        SELECT,
        WRITEBACK,
        REFILL,
        UPDATE
    } state_t;

    // Index of the lowest set bit; returns 0 when no bit is set.
    function automatic way_t first_one(input logic [NWAYS-1:0] v);
        way_t r;
        r = '0;
        for (int unsigned i = 0; i < NWAYS; i++) begin
            if (v[NWAYS-1-i]) begin
                r = way_t'(NWAYS-1-i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/repl_victim_sel.sv
// Combinational victim chooser for one 4-way set: prefers an invalid way,
// then a clean valid way, and falls back to the set's round-robin pointer.
module repl_victim_sel
    import cache_pkg::*;
(
    input  logic [NWAYS-1:0] valid,
    input  logic [NWAYS-1:0] dirty,
    input  way_t             rr,
    output way_t             way,
    output logic             need_wb
);

    // Priority select of the victim and whether it must be written back
    always_comb begin
        way = rr;
        if (!(&valid)) begin
            way = first_one(~valid);
        end else if (!(&dirty)) begin
            // every way is valid here, so ~dirty equals valid & ~dirty
            way = first_one(~dirty);
        end
        need_wb = valid[way] & dirty[way];
    end

endmodule

// File: rtl/cache_repl_ctrl.sv
// 4-way set-associative cache replacement controller: lookup, victim
// selection, writeback and refill handshakes, tag/valid/dirty bookkeeping.
// Optional statistics counters (miss_cnt, wb_cnt) when CACHE_REPL_STATS_EN
// is defined.
module cache_repl_ctrl
    import cache_pkg::*;
#(
    parameter int unsigned SETS  = 16,
    parameter int unsigned TAG_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [$clog2(SETS)-1:0]  req_set,
    input  logic [TAG_W-1:0]         req_tag,
    input  logic                     req_write,
    output logic                     resp_valid,
    output logic                     resp_hit,
    output way_t                     resp_way,
    output logic                     wb_valid,
    input  logic                     wb_ready,
    output logic [TAG_W-1:0]         wb_tag,
    output way_t                     wb_way,
    output logic                     fill_valid,
    input  logic                     fill_done,
    output way_t                     fill_way
`ifdef CACHE_REPL_STATS_EN
    ,
    output logic [15:0]              miss_cnt,
    output logic [15:0]              wb_cnt
`endif
);

    localparam int unsigned SET_W = $clog2(SETS);

    state_t               state;

    logic [NWAYS-1:0]     valid_q [SETS];
    logic [NWAYS-1:0]     dirty_q [SETS];
    way_t                 rr_q    [SETS];
    logic [TAG_W-1:0]     tag_q   [SETS][NWAYS];

    logic [SET_W-1:0]     set_q;
    logic [TAG_W-1:0]     tag_r;
    logic                 write_q;
    way_t                 victim_q;
    logic                 victim_rr_q;

    logic [NWAYS-1:0]     cur_valid;
    logic [NWAYS-1:0]     cur_dirty;
    way_t                 cur_rr;
    logic [NWAYS-1:0]     hit_vec;
    logic                 hit;
    way_t                 hit_way;
    way_t                 sel_way;
    logic                 sel_wb;
    logic                 sel_rr;

    // Tag compare of the latched request against the addressed set
    always_comb begin
        cur_valid = valid_q[set_q];
        cur_dirty = dirty_q[set_q];
        cur_rr    = rr_q[set_q];
        hit_vec   = '0;
        for (int unsigned i = 0; i < NWAYS; i++) begin
            hit_vec[i] = cur_valid[i] && (tag_q[set_q][i] == tag_r);
        end
        hit     = |hit_vec;
        hit_way = first_one(hit_vec);
        // the pointer only decides when no invalid or clean way exists
        sel_rr  = (&cur_valid) && (&cur_dirty);
    end

    repl_victim_sel u_victim_sel (
        .valid   (cur_valid),
        .dirty   (cur_dirty),
        .rr      (cur_rr),
        .way     (sel_way),
        .need_wb (sel_wb)
    );

    // Tag storage: written once per completed miss, never reset
    always_ff @(posedge clk) begin
        if (rst_n && state == UPDATE) begin
            tag_q[set_q][victim_q] <= tag_r;
        end
    end

    // Controller FSM with registered handshake/response outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            req_ready   <= 1'b0;
            resp_valid  <= 1'b0;
            resp_hit    <= 1'b0;
            resp_way    <= '0;
            wb_valid    <= 1'b0;
            wb_tag      <= '0;
            wb_way      <= '0;
            fill_valid  <= 1'b0;
            fill_way    <= '0;
            set_q       <= '0;
            tag_r       <= '0;
            write_q     <= 1'b0;
            victim_q    <= '0;
            victim_rr_q <= 1'b0;
            for (int unsigned s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                rr_q[s]    <= '0;
            end
`ifdef CACHE_REPL_STATS_EN
            miss_cnt    <= '0;
            wb_cnt      <= '0;
`endif
        end else begin
            resp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        set_q     <= req_set;
                        tag_r     <= req_tag;
                        write_q   <= req_write;
                        req_ready <= 1'b0;
                        state     <= LOOKUP;
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                LOOKUP: begin
                    if (hit) begin
                        resp_valid                <= 1'b1;
                        resp_hit                  <= 1'b1;
                        resp_way                  <= hit_way;
                        dirty_q[set_q][hit_way]   <= cur_dirty[hit_way] | write_q;
                        req_ready                 <= 1'b1;
                        state                     <= IDLE;
                    end else begin
                        state <= SELECT;
                    end
                end
                SELECT: begin
                    victim_q    <= sel_way;
                    victim_rr_q <= sel_rr;
`ifdef CACHE_REPL_STATS_EN
                    if (miss_cnt != 16'hFFFF) begin
                        miss_cnt <= miss_cnt + 16'd1;
                    end
`endif
                    if (sel_wb) begin
                        wb_valid <= 1'b1;
                        wb_tag   <= tag_q[set_q][sel_way];
                        wb_way   <= sel_way;
                        state    <= WRITEBACK;
                    end else begin
                        fill_valid <= 1'b1;
                        fill_way   <= sel_way;
                        state      <= REFILL;
                    end
                end
                WRITEBACK: begin
                    // fill_done is not looked at here; refill starts afterwards
                    if (wb_ready) begin
                        wb_valid   <= 1'b0;
                        fill_valid <= 1'b1;
                        fill_way   <= victim_q;
                        state      <= REFILL;
`ifdef CACHE_REPL_STATS_EN
                        if (wb_cnt != 16'hFFFF) begin
                            wb_cnt <= wb_cnt + 16'd1;
                        end
`endif
                    end
                end
                REFILL: begin
                    if (fill_done) begin
                        fill_valid <= 1'b0;
                        resp_valid <= 1'b1;
                        resp_hit   <= 1'b0;
                        resp_way   <= victim_q;
                        state      <= UPDATE;
                    end
                end
                UPDATE: begin
                    valid_q[set_q][victim_q] <= 1'b1;
                    dirty_q[set_q][victim_q] <= write_q;
                    if (victim_rr_q) begin
                        rr_q[set_q] <= way_t'(cur_rr + 2'd1);
                    end
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cache_repl_ctrl.sv
// Directed bench for cache_repl_ctrl: stimulus pushes expected responses into
// a queue, a negedge monitor pops and compares on every resp_valid pulse.
module tb_cache_repl_ctrl;
    import cache_pkg::*;

    localparam int unsigned SETS  = 16;
    localparam int unsigned TAG_W = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              req_valid;
    logic              req_ready;
    logic [3:0]        req_set;
    logic [TAG_W-1:0]  req_tag;
    logic              req_write;
    logic              resp_valid;
    logic              resp_hit;
    way_t              resp_way;
    logic              wb_valid;
    logic              wb_ready;
    logic [TAG_W-1:0]  wb_tag;
    way_t              wb_way;
    logic              fill_valid;
    logic              fill_done;
    way_t              fill_way;
`ifdef CACHE_REPL_STATS_EN
    logic [15:0]       miss_cnt;
    logic [15:0]       wb_cnt;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic hit;
        way_t way;
    } resp_t;

    resp_t exp_q[$];

    always #5 clk = ~clk;

    cache_repl_ctrl #(
        .SETS  (SETS),
        .TAG_W (TAG_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_set    (req_set),
        .req_tag    (req_tag),
        .req_write  (req_write),
        .resp_valid (resp_valid),
        .resp_hit   (resp_hit),
        .resp_way   (resp_way),
        .wb_valid   (wb_valid),
        .wb_ready   (wb_ready),
        .wb_tag     (wb_tag),
        .wb_way     (wb_way),
        .fill_valid (fill_valid),
        .fill_done  (fill_done),
        .fill_way   (fill_way)
`ifdef CACHE_REPL_STATS_EN
        ,
        .miss_cnt   (miss_cnt),
        .wb_cnt     (wb_cnt)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Response monitor: every pulse must match the oldest expectation
    always @(negedge clk) begin : monitor
        resp_t e;
        if (resp_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp actual=hit%0d_way%0d required=none", resp_hit, resp_way);
            end else begin
                e = exp_q.pop_front();
                chk("resp_hit", {31'd0, resp_hit}, {31'd0, e.hit});
                chk("resp_way", {30'd0, resp_way}, {30'd0, e.way});
            end
        end
    end

    task automatic do_req(input logic [3:0] s, input logic [TAG_W-1:0] t, input logic w);
        int n;
        n = 0;
        while (req_ready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        if (req_ready !== 1'b1) begin
            chk("req_ready_timeout", {31'd0, req_ready}, 32'd1);
        end
        req_valid = 1'b1;
        req_set   = s;
        req_tag   = t;
        req_write = w;
        tick();
        req_valid = 1'b0;
        chk("ready_low_lookup", {31'd0, req_ready}, 32'd0);
    endtask

    task automatic do_hit(input logic [3:0] s, input logic [TAG_W-1:0] t, input logic w,
                          input way_t way);
        exp_q.push_back(resp_t'({1'b1, way}));
        do_req(s, t, w);
        chk("lookup_no_resp", {31'd0, resp_valid}, 32'd0);
        tick();
        chk("hit_latency", {31'd0, resp_valid}, 32'd1);
        chk("hit_no_fill", {31'd0, fill_valid}, 32'd0);
        tick();
    endtask

    task automatic do_miss(input logic [3:0] s, input logic [TAG_W-1:0] t, input logic w,
                           input way_t way, input logic exp_wb, input logic [TAG_W-1:0] exp_wb_tag,
                           input int wb_hold, input logic both, input int fill_hold);
        exp_q.push_back(resp_t'({1'b0, way}));
        do_req(s, t, w);
        chk("miss_lookup_no_resp", {31'd0, resp_valid}, 32'd0);
        tick();
        chk("select_no_wb", {31'd0, wb_valid}, 32'd0);
        chk("select_no_fill", {31'd0, fill_valid}, 32'd0);
        tick();
        chk("wb_valid", {31'd0, wb_valid}, {31'd0, exp_wb});
        chk("fill_valid_start", {31'd0, fill_valid}, {31'd0, !exp_wb});
        if (exp_wb) begin
            chk("wb_tag", {24'd0, wb_tag}, {24'd0, exp_wb_tag});
            chk("wb_way", {30'd0, wb_way}, {30'd0, way});
            for (int i = 0; i < wb_hold; i++) begin
                tick();
                chk("wb_hold_valid", {31'd0, wb_valid}, 32'd1);
                chk("wb_hold_tag", {24'd0, wb_tag}, {24'd0, exp_wb_tag});
                chk("wb_hold_way", {30'd0, wb_way}, {30'd0, way});
                chk("wb_hold_no_fill", {31'd0, fill_valid}, 32'd0);
            end
            wb_ready  = 1'b1;
            fill_done = both;
            tick();
            wb_ready  = 1'b0;
            fill_done = 1'b0;
            chk("wb_released", {31'd0, wb_valid}, 32'd0);
            chk("fill_after_wb", {31'd0, fill_valid}, 32'd1);
            chk("no_resp_after_wb", {31'd0, resp_valid}, 32'd0);
            if (both) begin
                for (int i = 0; i < 2; i++) begin
                    tick();
                    chk("fill_wait_after_both", {31'd0, fill_valid}, 32'd1);
                    chk("no_resp_after_both", {31'd0, resp_valid}, 32'd0);
                end
            end
        end
        chk("fill_way", {30'd0, fill_way}, {30'd0, way});
        for (int i = 0; i < fill_hold; i++) begin
            tick();
            chk("fill_hold_valid", {31'd0, fill_valid}, 32'd1);
            chk("fill_hold_no_resp", {31'd0, resp_valid}, 32'd0);
        end
        fill_done = 1'b1;
        tick();
        fill_done = 1'b0;
        chk("update_resp", {31'd0, resp_valid}, 32'd1);
        chk("fill_dropped", {31'd0, fill_valid}, 32'd0);
        tick();
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin : stim
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_set   = '0;
        req_tag   = '0;
        req_write = 1'b0;
        wb_ready  = 1'b0;
        fill_done = 1'b0;
        repeat (3) tick();
        chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_resp_hit", {31'd0, resp_hit}, 32'd0);
        chk("rst_resp_way", {30'd0, resp_way}, 32'd0);
        chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        chk("rst_fill_valid", {31'd0, fill_valid}, 32'd0);
        chk("rst_wb_tag", {24'd0, wb_tag}, 32'd0);
        chk("rst_wb_way", {30'd0, wb_way}, 32'd0);
        chk("rst_fill_way", {30'd0, fill_way}, 32'd0);
        rst_n = 1'b1;
        tick();
        chk("ready_after_release", {31'd0, req_ready}, 32'd1);

        // set 3: clean miss into way 0, then write hit marks it dirty
        do_miss(4'd3, 8'h11, 1'b0, 2'd0, 1'b0, 8'h00, 0, 1'b0, 1);
        do_hit (4'd3, 8'h11, 1'b1, 2'd0);
        do_miss(4'd3, 8'h22, 1'b1, 2'd1, 1'b0, 8'h00, 0, 1'b0, 0);
        do_miss(4'd3, 8'h33, 1'b1, 2'd2, 1'b0, 8'h00, 0, 1'b0, 0);
        do_miss(4'd3, 8'h44, 1'b1, 2'd3, 1'b0, 8'h00, 0, 1'b0, 0);
        // all dirty: pointer 0 picks way 0, writeback held off 5 cycles
        do_miss(4'd3, 8'h55, 1'b1, 2'd0, 1'b1, 8'h11, 5, 1'b0, 2);
`ifdef CACHE_REPL_STATS_EN
        chk("miss_cnt_mid", {16'd0, miss_cnt}, 32'd5);
        chk("wb_cnt_mid", {16'd0, wb_cnt}, 32'd1);
`endif
        // pointer advanced to 1; wb_ready with fill_done completes only the writeback
        do_miss(4'd3, 8'h66, 1'b0, 2'd1, 1'b1, 8'h22, 0, 1'b1, 0);
        do_hit (4'd3, 8'h55, 1'b0, 2'd0);
        do_hit (4'd3, 8'h66, 1'b0, 2'd1);

        // set 6: ways 0,2 dirty and 1,3 clean -> clean way 1 chosen, pointer untouched
        do_miss(4'd6, 8'h60, 1'b1, 2'd0, 1'b0, 8'h00, 0, 1'b0, 0);
        do_miss(4'd6, 8'h61, 1'b0, 2'd1, 1'b0, 8'h00, 0, 1'b0, 0);
        do_miss(4'd6, 8'h62, 1'b1, 2'd2, 1'b0, 8'h00, 0, 1'b0, 0);
        do_miss(4'd6, 8'h63, 1'b0, 2'd3, 1'b0, 8'h00, 0, 1'b0, 0);
        do_miss(4'd6, 8'h64, 1'b0, 2'd1, 1'b0, 8'h00, 0, 1'b0, 0);
        do_hit (4'd6, 8'h64, 1'b1, 2'd1);
        do_hit (4'd6, 8'h63, 1'b1, 2'd3);
        do_miss(4'd6, 8'h65, 1'b0, 2'd0, 1'b1, 8'h60, 1, 1'b0, 0);
`ifdef CACHE_REPL_STATS_EN
        chk("miss_cnt_end", {16'd0, miss_cnt}, 32'd12);
        chk("wb_cnt_end", {16'd0, wb_cnt}, 32'd3);
`endif

        // reset in REFILL abandons the miss without a response
        do_req(4'd9, 8'h77, 1'b0);
        tick();
        tick();
        chk("refill_before_rst", {31'd0, fill_valid}, 32'd1);
        rst_n = 1'b0;
        tick();
        chk("rst_refill_fill_valid", {31'd0, fill_valid}, 32'd0);
        chk("rst_refill_req_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_refill_resp", {31'd0, resp_valid}, 32'd0);
        rst_n = 1'b1;
        tick();
        chk("ready_after_rst2", {31'd0, req_ready}, 32'd1);
`ifdef CACHE_REPL_STATS_EN
        chk("miss_cnt_cleared", {16'd0, miss_cnt}, 32'd0);
        chk("wb_cnt_cleared", {16'd0, wb_cnt}, 32'd0);
`endif
        do_miss(4'd9, 8'h77, 1'b0, 2'd0, 1'b0, 8'h00, 0, 1'b0, 0);
        do_miss(4'd3, 8'h55, 1'b0, 2'd0, 1'b0, 8'h00, 0, 1'b0, 0);

        repeat (3) tick();
        chk("resp_queue_empty", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
